fpu_addsub_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined FP add/sub unit (5-stage, fully pipelined, one issue per cycle) among NUM_REQ requesters.
- Arbitrates valid/ready requests and drives the unit's start/operands.
- Tracks the requester ID of every in-flight op in a tag pipeline and routes each result back to its owner as a one-cycle response pulse.
- Sits between the FP issue ports (e.g. scalar pipe, FMA/convert sequencer) and the add/sub unit instance.

---
 rtl/fpu_pkg.sv | 17 +
 rtl/fpu_addsub_sched_rr_arbiter.sv | 51 +++++
 rtl/fpu_addsub_sched.sv | 145 ++++++++++++++
 tb/tb_fpu_addsub_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP add/sub scheduler: unit latency, operand width,
// op encodings and the in-flight tag record.
package fpu_pkg;

    localparam int FPU_ADDSUB_LAT = 5;
    localparam int FP_W           = 32;
    localparam int TAG_ID_W       = 3;

    localparam logic FP_OP_ADD = 1'b0;
    localparam logic FP_OP_SUB = 1'b1;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } fp_tag_t;

endpackage

// File: rtl/fpu_addsub_sched_rr_arbiter.sv
// Round-robin arbiter: priority starts just after the last granted index; the
// pointer only moves on cycles where the grant is actually taken.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand_s;
    logic          found_s;
    logic          hit_s;

    // Walk the candidates ptr+1 .. ptr (mod N) and take the first requester.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        cand_s      = ptr_q;
        found_s     = 1'b0;
        hit_s       = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand_s              = (cand_s == IW'(N - 1)) ? '0 : cand_s + IW'(1);
            hit_s               = !found_s && req_i[cand_s];
            grant_o[cand_s]     = grant_o[cand_s] | hit_s;
            grant_idx_o         = hit_s ? cand_s : grant_idx_o;
            found_s             = found_s | hit_s;
        end
    end

    // Next pointer value.
    always_comb begin
        ptr_d = advance_i ? grant_idx_o : ptr_q;
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Shares one pipelined FP add/sub unit among NUM_REQ requesters and routes each
// result back to its issuer using a tag pipeline that mirrors the unit latency.
module fpu_addsub_sched
    import fpu_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  FPU_LAT = FPU_ADDSUB_LAT,
    parameter int  ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W   = $clog2(FPU_LAT + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_sub,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [FP_W-1:0]         resp_result,
    output logic                    fpu_start,
    output logic                    fpu_add_sub,
    output logic [FP_W-1:0]         fpu_a,
    output logic [FP_W-1:0]         fpu_b,
    input  logic                    fpu_ready,
    input  logic [FP_W-1:0]         fpu_result,
    output logic [CNT_W-1:0]        inflight,
    output logic                    err
);

    logic [NUM_REQ-1:0] req_masked_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_idx_s;
    fp_tag_t            tag_q [FPU_LAT];
    fp_tag_t            tag_in_s;
    fp_tag_t            tail_s;
    logic               deliver_s;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [FP_W-1:0]    resp_result_q, resp_result_d;
    logic               retire_q, retire_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               err_q, err_d;

    // No grants are offered while reset is held.
    always_comb begin
        if (rst) begin
            req_masked_s = '0;
        end else begin
            req_masked_s = req_valid;
        end
    end

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_masked_s),
        .advance_i   (fpu_start),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    assign req_ready = grant_s;
    assign fpu_start = |grant_s;

    // Grant is one-hot, so an AND-OR mux selects the winner and yields 0 when idle.
    always_comb begin
        fpu_add_sub = FP_OP_ADD;
        fpu_a       = '0;
        fpu_b       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fpu_add_sub = fpu_add_sub | (grant_s[i] & (req_sub[i] ? FP_OP_SUB : FP_OP_ADD));
            fpu_a       = fpu_a | ({FP_W{grant_s[i]}} & req_a[FP_W*i +: FP_W]);
            fpu_b       = fpu_b | ({FP_W{grant_s[i]}} & req_b[FP_W*i +: FP_W]);
        end
    end

    // Response, error and in-flight bookkeeping for the current cycle.
    always_comb begin
        tag_in_s       = '{valid: fpu_start, id: TAG_ID_W'(grant_idx_s)};
        tail_s         = tag_q[FPU_LAT-1];
        deliver_s      = fpu_ready && tail_s.valid;
        resp_valid_d   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid_d[i] = deliver_s && (tail_s.id == TAG_ID_W'(i));
        end
        resp_result_d  = deliver_s ? fpu_result : resp_result_q;
        err_d          = err_q | (fpu_ready != tail_s.valid);
        // A dropped tag still retires so the counter cannot leak.
        retire_d       = tail_s.valid;
        inflight_d     = inflight_q;
        case ({fpu_start, retire_q})
            2'b10: begin
                if (inflight_q != CNT_W'(FPU_LAT + 1)) begin
                    inflight_d = inflight_q + CNT_W'(1);
                end else begin
                    inflight_d = inflight_q;
                end
            end
            2'b01: begin
                if (inflight_q != '0) begin
                    inflight_d = inflight_q - CNT_W'(1);
                end else begin
                    inflight_d = inflight_q;
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    // Tag pipeline shifting in lock-step with the unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FPU_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in_s;
            for (int i = 1; i < FPU_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Registered response, counters and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            retire_q      <= 1'b0;
            inflight_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            retire_q      <= retire_d;
            inflight_q    <= inflight_d;
            err_q         <= err_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign inflight    = inflight_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Directed/table-driven bench for fpu_addsub_sched with a behavioural 5-stage
// FP add/sub unit and an issue-order response scoreboard.
module tb_fpu_addsub_sched;

    localparam int NR  = 3;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] req_sub = '0;
    logic [32*NR-1:0] req_a = '0;
    logic [32*NR-1:0] req_b = '0;
    logic [NR-1:0] resp_valid;
    logic [31:0]   resp_result;
    logic          fpu_start, fpu_add_sub;
    logic [31:0]   fpu_a, fpu_b;
    logic          fpu_ready;
    logic [31:0]   fpu_result;
    logic [2:0]    inflight;
    logic          err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int resp_count = 0;
    int max_infl = 0;
    logic stub_mode = 1'b0;
    logic stub_ready = 1'b0;

    fpu_addsub_sched #(.NUM_REQ(NR), .FPU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_sub(req_sub), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_result(resp_result),
        .fpu_start(fpu_start), .fpu_add_sub(fpu_add_sub), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_ready(fpu_ready), .fpu_result(fpu_result),
        .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    function automatic real sp2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'd0, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        return r2sp(s ? sp2r(a) - sp2r(b) : sp2r(a) + sp2r(b));
    endfunction

    // Behavioural unit: fixed 5-cycle pipeline, reset shared with the scheduler.
    logic        mp_v [LAT];
    logic [31:0] mp_r [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin mp_v[i] <= 1'b0; mp_r[i] <= 32'd0; end
        end else begin
            mp_v[0] <= fpu_start;
            mp_r[0] <= fp_op(fpu_a, fpu_b, fpu_add_sub);
            for (int i = 1; i < LAT; i++) begin mp_v[i] <= mp_v[i-1]; mp_r[i] <= mp_r[i-1]; end
        end
    end
    assign fpu_ready  = stub_mode ? stub_ready : mp_v[LAT-1];
    assign fpu_result = mp_r[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {int id; logic [31:0] res; int c;} exp_t;
    exp_t sb[$];

    // Scoreboard: record handshakes, match responses in issue order with 6-cycle latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            check("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
            check("infl_bound", 32'(inflight <= 3'd6), 32'd1);
            if (int'(inflight) > max_infl) max_infl = int'(inflight);
            if (resp_valid != '0) begin
                resp_count++;
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", 32'(resp_valid), 32'(1 << e.id));
                    check("resp_res", resp_result, e.res);
                    check("resp_lat", 32'(cyc - e.c), 32'd6);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{i, fp_op(req_a[32*i +: 32], req_b[32*i +: 32], req_sub[i]), cyc});
                end
            end
        end
    end

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_sub[id] = s;
    endtask

    task automatic do_reset();
        adv();
        rst = 1'b1;
        req_valid = '0;
        adv();
        rst = 1'b0;
    endtask

    task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [31:0] exp_res);
        set_req(id, a, b, s);
        req_valid = NR'(1 << id);
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'(1 << id));
        check("single_start", 32'(fpu_start), 32'd1);
        adv();
        req_valid = '0;
        check("single_infl1", 32'(inflight), 32'd1);
        repeat (5) adv();
        @(negedge clk);
        check("single_resp_v", 32'(resp_valid), 32'(1 << id));
        check("single_resp_r", resp_result, exp_res);
        adv();
        @(negedge clk);
        check("single_infl0", 32'(inflight), 32'd0);
        check("single_resp_off", 32'(resp_valid), 32'd0);
    endtask

    typedef struct {logic [31:0] a; logic [31:0] b; logic s; logic [31:0] exp;} vec_t;
    vec_t vecs [6];
    logic [31:0] vals [4];
    logic [NR-1:0] cg [4];
    logic [31:0] cr [4];

    initial begin
        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
        vecs[1] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
        vecs[2] = '{32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000};
        vecs[3] = '{32'h40000000, 32'h3F000000, 1'b1, 32'h3FC00000};
        vecs[4] = '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000};
        vecs[5] = '{32'h41200000, 32'h40800000, 1'b1, 32'h40C00000};
        vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h3F000000; vals[3] = 32'h40400000;
        cg[0] = 3'b010; cg[1] = 3'b001; cg[2] = 3'b010; cg[3] = 3'b001;
        cr[0] = 32'h40000000; cr[1] = 32'h40400000; cr[2] = 32'h40000000; cr[3] = 32'h40400000;

        // Reset gating and reset values.
        rst = 1'b1;
        req_valid = '1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(fpu_start), 32'd0);
        do_reset();
        @(negedge clk);
        check("rst_resp_v", 32'(resp_valid), 32'd0);
        check("rst_resp_r", resp_result, 32'd0);
        check("rst_infl", 32'(inflight), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        adv();
        single_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);

        for (int k = 0; k < 6; k++) begin
            adv();
            single_op(k % NR, vecs[k].a, vecs[k].b, vecs[k].s, vecs[k].exp);
        end

        // Contention between requesters 0 and 1 right after reset.
        do_reset();
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        set_req(1, 32'h40400000, 32'h3F800000, 1'b1);
        req_valid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cont_grant", 32'(req_ready), 32'(cg[k]));
            adv();
        end
        req_valid = '0;
        adv(); adv();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cont_resp_v", 32'(resp_valid), 32'(cg[k]));
            check("cont_resp_r", resp_result, cr[k]);
            adv();
        end

        // Streaming: requester 0 alone, 20 back-to-back ops.
        do_reset();
        resp_count = 0;
        max_infl = 0;
        req_valid = 3'b001;
        for (int k = 0; k < 20; k++) begin
            set_req(0, vals[k % 4], vals[(k + 1) % 4], k[0]);
            @(negedge clk);
            check("stream_ready", 32'(req_ready), 32'd1);
            adv();
        end
        req_valid = '0;
        repeat (10) adv();
        check("stream_count", 32'(resp_count), 32'd20);
        check("stream_max_infl", 32'(max_infl), 32'd6);
        check("stream_infl0", 32'(inflight), 32'd0);

        // Random valid patterns with idle gaps on three requesters.
        resp_count = 0;
        for (int k = 0; k < 80; k++) begin
            req_valid = NR'($urandom_range(0, 7));
            for (int i = 0; i < NR; i++) begin
                set_req(i, vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
            end
            adv();
        end
        req_valid = '0;
        repeat (10) adv();
        check("rand_drain", 32'(sb.size()), 32'd0);
        check("rand_some_resp", 32'(resp_count > 0), 32'd1);
        check("rand_err", 32'(err), 32'd0);

        // Reset while ops are in flight.
        do_reset();
        set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
        req_valid = 3'b001;
        adv(); adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("midrst_resp", 32'(resp_valid), 32'd0);
            adv();
        end
        check("midrst_infl", 32'(inflight), 32'd0);
        check("midrst_err", 32'(err), 32'd0);

        // Stray ready from a stub unit with nothing issued.
        stub_mode = 1'b1;
        stub_ready = 1'b0;
        do_reset();
        adv(); adv(); adv();
        stub_ready = 1'b1;
        @(negedge clk);
        check("err_before", 32'(err), 32'd0);
        adv();
        stub_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("err_sticky", 32'(err), 32'd1);
            check("err_no_resp", 32'(resp_valid), 32'd0);
            adv();
        end
        do_reset();
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        stub_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
